// File: rtl/mem_pr_bridge_pkg.sv
// Shared definitions for the memory-stage bus bridge: FSM encodings and bus defaults.
package mem_pr_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } pr_state_e;

  localparam logic [31:0] PR_BASE_DEF  = 32'h0000_7f00;
  localparam logic        BUSERR_RDATA = 1'b0;

endpackage

// File: rtl/mem_pr_bridge_pr_decode.sv
// Address decoder: classifies a byte address as DM or peripheral space and
// splits peripheral addresses into slot index and in-slot offset.
module mem_pr_bridge_pr_decode #(
  parameter logic [31:0] PR_BASE   = 32'h0000_7f00,
  parameter int          SPAN_LOG2 = 4,
  parameter int          NDEV      = 4,
  parameter int          SLOT_W    = 2
) (
  input  logic [31:0]          i_addr,
  output logic                 o_is_pr,
  output logic                 o_mapped,
  output logic [SLOT_W-1:0]    o_slot,
  output logic [SPAN_LOG2-1:0] o_offset
);

  logic [31:0] w_diff;
  logic [31:0] w_slot_full;

  assign w_diff      = i_addr - PR_BASE;
  assign w_slot_full = w_diff >> SPAN_LOG2;

  // The full slot number is compared so addresses past the last slot never alias.
  assign o_is_pr  = (i_addr >= PR_BASE);
  assign o_mapped = o_is_pr && (w_slot_full < 32'(NDEV));
  assign o_slot   = w_slot_full[SLOT_W-1:0];
  assign o_offset = w_diff[SPAN_LOG2-1:0];

endmodule

// File: rtl/mem_pr_bridge.sv
// Memory-stage bridge: zero-wait DM pass-through plus a stalling, timeout-bounded
// select/ready handshake towards NDEV memory-mapped peripherals.
module mem_pr_bridge
  import mem_pr_bridge_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NDEV      = 4,
  parameter logic [31:0] PR_BASE   = PR_BASE_DEF,
  parameter int          SPAN_LOG2 = 4,
  parameter int          TIMEOUT   = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req,
  input  logic                   i_write,
  input  logic [31:0]            i_addr,
  input  logic [DATA_W-1:0]      i_wdata,
  input  logic [DATA_W/8-1:0]    i_mask,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_stall,
  output logic                   o_bus_err,
  output logic                   o_dm_read,
  output logic                   o_dm_write,
  output logic [31:0]            o_dm_addr,
  output logic [DATA_W-1:0]      o_dm_wdata,
  output logic [DATA_W/8-1:0]    o_dm_mask,
  input  logic [DATA_W-1:0]      i_dm_rdata,
  output logic [NDEV-1:0]        o_pr_sel,
  output logic                   o_pr_write,
  output logic [SPAN_LOG2-1:0]   o_pr_addr,
  output logic [DATA_W-1:0]      o_pr_wdata,
  output logic [DATA_W/8-1:0]    o_pr_mask,
  input  logic [NDEV*DATA_W-1:0] i_pr_rdata,
  input  logic [NDEV-1:0]        i_pr_ready
);

  localparam int SLOT_W = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int MASK_W = DATA_W / 8;

  logic                 w_is_pr;
  logic                 w_mapped;
  logic [SLOT_W-1:0]    w_slot;
  logic [SPAN_LOG2-1:0] w_offset;
  logic                 w_idle;
  logic                 w_accept;
  logic                 w_unmapped;
  logic [DATA_W-1:0]    w_pr_rdata;

  pr_state_e            r_state;
  logic [NDEV-1:0]      r_pr_sel;
  logic                 r_pr_write;
  logic [DATA_W-1:0]    r_rdata;
  logic [7:0]           r_cnt;
  logic                 r_err;
  logic [SLOT_W-1:0]    r_slot;
  logic [SPAN_LOG2-1:0] r_off;
  logic [DATA_W-1:0]    r_wdata;
  logic [MASK_W-1:0]    r_mask;

  mem_pr_bridge_pr_decode #(
    .PR_BASE  (PR_BASE),
    .SPAN_LOG2(SPAN_LOG2),
    .NDEV     (NDEV),
    .SLOT_W   (SLOT_W)
  ) u_decode (
    .i_addr  (i_addr),
    .o_is_pr (w_is_pr),
    .o_mapped(w_mapped),
    .o_slot  (w_slot),
    .o_offset(w_offset)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle && i_req && w_is_pr && w_mapped;
  assign w_unmapped = w_idle && i_req && w_is_pr && !w_mapped;
  assign w_pr_rdata = i_pr_rdata[r_slot*DATA_W +: DATA_W];

  // DM strobes only fire for a DM-space request seen while the FSM is idle.
  assign o_dm_read  = i_req && !i_write && !w_is_pr && w_idle;
  assign o_dm_write = i_req &&  i_write && !w_is_pr && w_idle;
  assign o_dm_addr  = i_addr;
  assign o_dm_wdata = i_wdata;
  assign o_dm_mask  = i_mask;

  assign o_stall   = w_accept || (r_state == ST_WAIT);
  assign o_bus_err = w_unmapped || ((r_state == ST_DONE) && r_err);
  assign o_rdata   = (r_state == ST_DONE)     ? r_rdata :
                     (w_is_pr || !w_idle)     ? {DATA_W{BUSERR_RDATA}} :
                                                i_dm_rdata;

  assign o_pr_sel   = r_pr_sel;
  assign o_pr_write = r_pr_write;
  assign o_pr_addr  = r_off;
  assign o_pr_wdata = r_wdata;
  assign o_pr_mask  = r_mask;

  // Transaction payload is captured once at accept and held stable through WAIT.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_slot  <= w_slot;
      r_off   <= w_offset;
      r_wdata <= i_wdata;
      r_mask  <= i_mask;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_pr_sel   <= '0;
      r_pr_write <= 1'b0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_err <= 1'b0;
          if (w_accept) begin
            r_pr_sel   <= NDEV'(1) << w_slot;
            r_pr_write <= i_write;
            r_cnt      <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_pr_ready[r_slot]) begin
            r_rdata    <= r_pr_write ? '0 : w_pr_rdata;
            r_pr_sel   <= '0;
            r_pr_write <= 1'b0;
            r_state    <= ST_DONE;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_rdata    <= {DATA_W{BUSERR_RDATA}};
            r_err      <= 1'b1;
            r_pr_sel   <= '0;
            r_pr_write <= 1'b0;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pr_bridge.sv
// Directed bench for mem_pr_bridge: idle-state decode table plus peripheral handshake sequences.
module tb_mem_pr_bridge;

  localparam int DATA_W  = 32;
  localparam int NDEV    = 4;
  localparam int TIMEOUT = 15;

  logic                   clk;
  logic                   rst_n;
  logic                   req;
  logic                   write;
  logic [31:0]            addr;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W/8-1:0]    mask;
  logic [DATA_W-1:0]      rdata;
  logic                   stall;
  logic                   bus_err;
  logic                   dm_read;
  logic                   dm_write;
  logic [31:0]            dm_addr;
  logic [DATA_W-1:0]      dm_wdata;
  logic [DATA_W/8-1:0]    dm_mask;
  logic [DATA_W-1:0]      dm_rdata;
  logic [NDEV-1:0]        pr_sel;
  logic                   pr_write;
  logic [3:0]             pr_addr;
  logic [DATA_W-1:0]      pr_wdata;
  logic [DATA_W/8-1:0]    pr_mask;
  logic [NDEV*DATA_W-1:0] pr_rdata;
  logic [NDEV-1:0]        pr_ready;

  int checks = 0;
  int errors = 0;

  mem_pr_bridge #(.DATA_W(DATA_W), .NDEV(NDEV), .PR_BASE(32'h7f00),
                  .SPAN_LOG2(4), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_write(write), .i_addr(addr),
    .i_wdata(wdata), .i_mask(mask), .o_rdata(rdata), .o_stall(stall),
    .o_bus_err(bus_err), .o_dm_read(dm_read), .o_dm_write(dm_write),
    .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata), .o_dm_mask(dm_mask),
    .i_dm_rdata(dm_rdata), .o_pr_sel(pr_sel), .o_pr_write(pr_write),
    .o_pr_addr(pr_addr), .o_pr_wdata(pr_wdata), .o_pr_mask(pr_mask),
    .i_pr_rdata(pr_rdata), .i_pr_ready(pr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dm_rdata;
    logic [31:0] exp_rdata;
    logic        exp_stall;
    logic        exp_err;
    logic        exp_dm_read;
    logic        exp_dm_write;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 32'h0040, 32'h0,    32'h1234, 32'h1234, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0100, 32'h55,   32'h9999, 32'h9999, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h7eff, 32'h0,    32'h4242, 32'h4242, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h7f40, 32'h77,   32'h1111, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h7fff, 32'h0,    32'h2222, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h7f00, 32'h0,    32'h3333, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; req = 1'b0; write = 1'b0; addr = 32'h0; wdata = '0; mask = '0;
    dm_rdata = 32'h5555; pr_rdata = '0; pr_ready = '0;
    #3;
    chk("reset_stall",  64'(stall),   64'h0);
    chk("reset_prsel",  64'(pr_sel),  64'h0);
    chk("reset_buserr", 64'(bus_err), 64'h0);
    chk("reset_rdata_dm", 64'(rdata), 64'h5555);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Idle-state decode table
    for (int i = 0; i < 6; i++) begin
      req = vecs[i].req; write = vecs[i].write; addr = vecs[i].addr;
      wdata = vecs[i].wdata; mask = 4'hf; dm_rdata = vecs[i].dm_rdata;
      #2;
      chk($sformatf("vec%0d_rdata", i),    64'(rdata),    64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_stall", i),    64'(stall),    64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_buserr", i),   64'(bus_err),  64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_dmread", i),   64'(dm_read),  64'(vecs[i].exp_dm_read));
      chk($sformatf("vec%0d_dmwrite", i),  64'(dm_write), 64'(vecs[i].exp_dm_write));
      chk($sformatf("vec%0d_prsel", i),    64'(pr_sel),   64'h0);
      chk($sformatf("vec%0d_dmaddr", i),   64'(dm_addr),  64'(vecs[i].addr));
      chk($sformatf("vec%0d_dmwdata", i),  64'(dm_wdata), 64'(vecs[i].wdata));
      tick();
    end

    // Slot-1 store, ready three cycles after accept
    req = 1'b1; write = 1'b1; addr = 32'h7f14; wdata = 32'hAB; mask = 4'h3;
    #2;
    chk("st1_accept_stall", 64'(stall),    64'h1);
    chk("st1_accept_dmwr",  64'(dm_write), 64'h0);
    chk("st1_accept_sel",   64'(pr_sel),   64'h0);
    tick();
    wdata = 32'hFFFF;
    for (int c = 1; c <= 3; c++) begin
      pr_ready = (c == 1) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      #2;
      chk($sformatf("st1_c%0d_sel", c),    64'(pr_sel),   64'h2);
      chk($sformatf("st1_c%0d_write", c),  64'(pr_write), 64'h1);
      chk($sformatf("st1_c%0d_addr", c),   64'(pr_addr),  64'h4);
      chk($sformatf("st1_c%0d_wdata", c),  64'(pr_wdata), 64'hAB);
      chk($sformatf("st1_c%0d_mask", c),   64'(pr_mask),  64'h3);
      chk($sformatf("st1_c%0d_stall", c),  64'(stall),    64'h1);
      tick();
    end
    pr_ready = '0;
    #2;
    chk("st1_done_stall", 64'(stall),   64'h0);
    chk("st1_done_sel",   64'(pr_sel),  64'h0);
    chk("st1_done_wr",    64'(pr_write), 64'h0);
    chk("st1_done_err",   64'(bus_err), 64'h0);
    chk("st1_done_rdata", 64'(rdata),   64'h0);
    tick();
    req = 1'b0;
    #2;
    chk("st1_after_stall", 64'(stall), 64'h0);
    tick();

    // Slot-0 load, ready in the first select cycle
    req = 1'b1; write = 1'b0; addr = 32'h7f00;
    #2;
    chk("ld0_accept_stall", 64'(stall), 64'h1);
    tick();
    pr_ready = 4'b0001; pr_rdata[0 +: 32] = 32'hDEAD;
    #2;
    chk("ld0_wait_sel",   64'(pr_sel),   64'h1);
    chk("ld0_wait_write", 64'(pr_write), 64'h0);
    chk("ld0_wait_stall", 64'(stall),    64'h1);
    tick();
    pr_ready = '0; pr_rdata[0 +: 32] = 32'hBEEF;
    #2;
    chk("ld0_done_stall", 64'(stall),   64'h0);
    chk("ld0_done_rdata", 64'(rdata),   64'hDEAD);
    chk("ld0_done_err",   64'(bus_err), 64'h0);
    tick();
    req = 1'b0;
    tick();

    // Slot-2 load that never completes
    req = 1'b1; write = 1'b0; addr = 32'h7f20; pr_rdata[64 +: 32] = 32'hABCD;
    pr_ready = 4'b1011;
    n = 0;
    #2;
    while (stall && n < 100) begin
      n++;
      tick();
      #1;
    end
    chk("to_stall_cycles", 64'(n),       64'(TIMEOUT + 1));
    chk("to_done_err",     64'(bus_err), 64'h1);
    chk("to_done_rdata",   64'(rdata),   64'h0);
    chk("to_done_sel",     64'(pr_sel),  64'h0);
    tick();
    req = 1'b0; pr_ready = '0;
    #2;
    chk("to_after_err", 64'(bus_err), 64'h0);
    tick();

    // Reset while waiting on slot 3
    req = 1'b1; write = 1'b1; addr = 32'h7f30; wdata = 32'h11;
    tick();
    #2;
    chk("rst_wait_sel", 64'(pr_sel), 64'h8);
    req = 1'b0; addr = 32'h0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_sel",   64'(pr_sel),   64'h0);
    chk("rst_async_stall", 64'(stall),    64'h0);
    chk("rst_async_wr",    64'(pr_write), 64'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    pr_ready = 4'b1000;
    tick();
    #2;
    chk("rst_late_sel",   64'(pr_sel),  64'h0);
    chk("rst_late_stall", 64'(stall),   64'h0);
    chk("rst_late_err",   64'(bus_err), 64'h0);
    pr_ready = '0;
    req = 1'b1; write = 1'b0; addr = 32'h0080; dm_rdata = 32'hCAFE;
    #1;
    chk("rst_dm_rdata", 64'(rdata),   64'hCAFE);
    chk("rst_dm_read",  64'(dm_read), 64'h1);
    chk("rst_dm_stall", 64'(stall),   64'h0);
    tick();
    req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
